// File: rtl/nnrv_mem_hs.sv
// Memory-stage handshake: accepts one op from execute, runs a single-beat bus
// transaction for aligned loads/stores and produces one writeback result.
module nnrv_mem_hs #(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_exec_valid,
  output logic              o_exec_ready,
  input  logic              i_exec_rd_en,
  input  logic [4:0]        i_exec_rd,
  input  logic [XLEN-1:0]   i_exec_rd_reg,
  input  logic              i_exec_ram_rd_en,
  input  logic              i_exec_ram_wr_en,
  input  logic [XLEN-1:0]   i_exec_ram_addr,
  input  logic [XLEN-1:0]   i_exec_ram_data,
  input  logic [1:0]        i_exec_size,
  input  logic              i_exec_sign,
  output logic              o_ram_req,
  output logic              o_ram_we,
  output logic [XLEN-1:0]   o_ram_addr,
  output logic [XLEN/8-1:0] o_ram_mask,
  output logic [XLEN-1:0]   o_ram_wdata,
  input  logic              i_ram_ack,
  input  logic [XLEN-1:0]   i_ram_rdata,
  output logic              o_wb_valid,
  output logic              o_wb_rd_en,
  output logic [4:0]        o_wb_rd,
  output logic [XLEN-1:0]   o_wb_rd_reg,
  output logic              o_misalign,
  output logic              o_bus_err
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam logic [7:0] TMO_LIM = 8'(TIMEOUT_CYC);

  typedef enum logic {IDLE, BUSY} state_t;

  function automatic logic misaligned(input logic [1:0] sz, input logic [OFFW-1:0] off);
    logic [OFFW-1:0] low;
    if (sz == 2'd3 && XLEN == 32) return 1'b1;
    case (sz)
      2'd0:    low = '0;
      2'd1:    low = OFFW'(1);
      2'd2:    low = OFFW'(3);
      default: low = OFFW'(7);
    endcase
    return |(off & low);
  endfunction

  function automatic logic [NB-1:0] lane_mask(input logic [1:0] sz, input logic [OFFW-1:0] off);
    logic [2*NB-1:0] m;
    m = '0;
    case (sz)
      2'd0:    m[0]    = 1'b1;
      2'd1:    m[1:0]  = 2'b11;
      2'd2:    m[3:0]  = 4'hF;
      default: m[NB-1:0] = '1;
    endcase
    m = m << off;
    return m[NB-1:0];
  endfunction

  // Left-justify the selected bytes, then shift back arithmetically or logically.
  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] rdata,
                                                  input logic [OFFW-1:0] off,
                                                  input logic [1:0]      sz,
                                                  input logic            sgn);
    logic [XLEN-1:0]        shifted;
    logic signed [XLEN-1:0] top;
    int                     pad;
    shifted = rdata >> {off, 3'b000};
    pad     = (sz == 2'd3) ? 0 : XLEN - (8 << sz);
    top     = shifted << pad;
    if (sgn) begin
      top = top >>> pad;
      return top;
    end
    shifted = shifted << pad;
    return shifted >> pad;
  endfunction

  state_t          state;
  logic [7:0]      tmo_cnt;
  logic [OFFW-1:0] off_p1;
  logic [1:0]      size_p1;
  logic            sign_p1;
  logic            load_p1;
  logic            rd_en_p1;
  logic [4:0]      rd_p1;

  logic [OFFW-1:0] off_p0;
  logic            is_mem_p0;
  logic            mis_p0;

  assign off_p0       = i_exec_ram_addr[OFFW-1:0];
  assign is_mem_p0    = i_exec_ram_rd_en | i_exec_ram_wr_en;
  assign mis_p0       = misaligned(i_exec_size, off_p0);
  assign o_exec_ready = (state == IDLE) & i_rst_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      off_p1      <= '0;
      size_p1     <= '0;
      sign_p1     <= 1'b0;
      load_p1     <= 1'b0;
      rd_en_p1    <= 1'b0;
      rd_p1       <= '0;
      o_ram_req   <= 1'b0;
      o_ram_we    <= 1'b0;
      o_ram_addr  <= '0;
      o_ram_mask  <= '0;
      o_ram_wdata <= '0;
      o_wb_valid  <= 1'b0;
      o_wb_rd_en  <= 1'b0;
      o_wb_rd     <= '0;
      o_wb_rd_reg <= '0;
      o_misalign  <= 1'b0;
      o_bus_err   <= 1'b0;
    end else begin
      o_wb_valid <= 1'b0;
      o_wb_rd_en <= 1'b0;
      o_misalign <= 1'b0;
      o_bus_err  <= 1'b0;
      case (state)
        // p0 -> p1: accept from execute; ALU results and faults retire at once
        IDLE: begin
          if (i_exec_valid) begin
            if (!is_mem_p0) begin
              o_wb_valid  <= 1'b1;
              o_wb_rd_en  <= i_exec_rd_en;
              o_wb_rd     <= i_exec_rd;
              o_wb_rd_reg <= i_exec_rd_reg;
            end else if (mis_p0) begin
              o_wb_valid  <= 1'b1;
              o_misalign  <= 1'b1;
              o_wb_rd     <= i_exec_rd;
              o_wb_rd_reg <= '0;
            end else begin
              state       <= BUSY;
              tmo_cnt     <= '0;
              off_p1      <= off_p0;
              size_p1     <= i_exec_size;
              sign_p1     <= i_exec_sign;
              load_p1     <= i_exec_ram_rd_en;
              rd_en_p1    <= i_exec_rd_en;
              rd_p1       <= i_exec_rd;
              o_ram_req   <= 1'b1;
              o_ram_we    <= i_exec_ram_wr_en & ~i_exec_ram_rd_en;
              o_ram_addr  <= {i_exec_ram_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
              o_ram_mask  <= lane_mask(i_exec_size, off_p0);
              o_ram_wdata <= i_exec_ram_data << {off_p0, 3'b000};
            end
          end
        end
        // p1 -> p2: wait for ack; an ack on the limit cycle still completes
        BUSY: begin
          if (i_ram_ack || (tmo_cnt + 8'd1 == TMO_LIM)) begin
            state       <= IDLE;
            o_ram_req   <= 1'b0;
            o_ram_we    <= 1'b0;
            o_ram_addr  <= '0;
            o_ram_mask  <= '0;
            o_ram_wdata <= '0;
            o_wb_valid  <= 1'b1;
            o_wb_rd     <= rd_p1;
          end
          if (i_ram_ack) begin
            o_wb_rd_en  <= load_p1 & rd_en_p1;
            o_wb_rd_reg <= load_p1 ? load_extend(i_ram_rdata, off_p1, size_p1, sign_p1) : '0;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
            if (tmo_cnt + 8'd1 == TMO_LIM) begin
              o_bus_err   <= 1'b1;
              o_wb_rd_reg <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nnrv_mem_hs.sv
// Bench for nnrv_mem_hs: a 32-bit and a 64-bit instance driven by directed ops,
// checked every cycle against a cycle-indexed transaction model.
module tb_nnrv_mem_hs;

  localparam int TMO = 4;

  typedef struct {
    logic        rd_en;
    logic [4:0]  rd;
    logic [63:0] reg_v;
    logic        mis;
    logic        err;
    logic        chk_reg;
  } wb_t;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [7:0]  mask;
    logic [63:0] wdata;
  } rq_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel64 = 1'b0;
  logic        running = 1'b0;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  logic        exec_valid = 1'b0, rd_en = 1'b0, ld = 1'b0, st = 1'b0, sgn = 1'b0, ack = 1'b0;
  logic [4:0]  rd = '0;
  logic [1:0]  size = '0;
  logic [63:0] rd_reg_in = '0, addr_in = '0, data_in = '0, rdata_in = '0;

  logic        rdy32, req32, we32, wbv32, wbe32, mis32, err32;
  logic [31:0] raddr32, wdata32, wbreg32;
  logic [3:0]  mask32;
  logic [4:0]  wbrd32;
  logic        rdy64, req64, we64, wbv64, wbe64, mis64, err64;
  logic [63:0] raddr64, wdata64, wbreg64;
  logic [7:0]  mask64;
  logic [4:0]  wbrd64;

  logic        dut_rdy, dut_req, dut_we, dut_wbv, dut_wbe, dut_mis, dut_err;
  logic [63:0] dut_addr, dut_wdata, dut_wbreg;
  logic [7:0]  dut_mask;
  logic [4:0]  dut_wbrd;

  wb_t exp_wb[int];
  rq_t exp_req[int];
  logic [63:0] last_wb_reg, last_addr, last_wdata;
  logic [7:0]  last_mask;
  logic        last_we;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nnrv_mem_hs #(.XLEN(32), .TIMEOUT_CYC(TMO)) u_dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_exec_valid(exec_valid & ~sel64), .o_exec_ready(rdy32),
    .i_exec_rd_en(rd_en), .i_exec_rd(rd), .i_exec_rd_reg(rd_reg_in[31:0]),
    .i_exec_ram_rd_en(ld), .i_exec_ram_wr_en(st), .i_exec_ram_addr(addr_in[31:0]),
    .i_exec_ram_data(data_in[31:0]), .i_exec_size(size), .i_exec_sign(sgn),
    .o_ram_req(req32), .o_ram_we(we32), .o_ram_addr(raddr32), .o_ram_mask(mask32),
    .o_ram_wdata(wdata32), .i_ram_ack(ack & ~sel64), .i_ram_rdata(rdata_in[31:0]),
    .o_wb_valid(wbv32), .o_wb_rd_en(wbe32), .o_wb_rd(wbrd32), .o_wb_rd_reg(wbreg32),
    .o_misalign(mis32), .o_bus_err(err32));

  nnrv_mem_hs #(.XLEN(64), .TIMEOUT_CYC(TMO)) u_dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_exec_valid(exec_valid & sel64), .o_exec_ready(rdy64),
    .i_exec_rd_en(rd_en), .i_exec_rd(rd), .i_exec_rd_reg(rd_reg_in),
    .i_exec_ram_rd_en(ld), .i_exec_ram_wr_en(st), .i_exec_ram_addr(addr_in),
    .i_exec_ram_data(data_in), .i_exec_size(size), .i_exec_sign(sgn),
    .o_ram_req(req64), .o_ram_we(we64), .o_ram_addr(raddr64), .o_ram_mask(mask64),
    .o_ram_wdata(wdata64), .i_ram_ack(ack & sel64), .i_ram_rdata(rdata_in),
    .o_wb_valid(wbv64), .o_wb_rd_en(wbe64), .o_wb_rd(wbrd64), .o_wb_rd_reg(wbreg64),
    .o_misalign(mis64), .o_bus_err(err64));

  always_comb begin
    if (sel64) begin
      dut_rdy = rdy64; dut_req = req64; dut_we = we64; dut_wbv = wbv64; dut_wbe = wbe64;
      dut_mis = mis64; dut_err = err64; dut_addr = raddr64; dut_wdata = wdata64;
      dut_wbreg = wbreg64; dut_mask = mask64; dut_wbrd = wbrd64;
    end else begin
      dut_rdy = rdy32; dut_req = req32; dut_we = we32; dut_wbv = wbv32; dut_wbe = wbe32;
      dut_mis = mis32; dut_err = err32; dut_addr = {32'b0, raddr32}; dut_wdata = {32'b0, wdata32};
      dut_wbreg = {32'b0, wbreg32}; dut_mask = {4'b0, mask32}; dut_wbrd = wbrd32;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (xlen=%0d cyc=%0d) actual=%h required=%h", name, sel64 ? 64 : 32, cyc, act, exp);
    end
  endtask

  // Load result: pick nbytes at the byte offset, then extend.
  function automatic logic [63:0] m_load(input logic [63:0] rdata, input int off, input int nb,
                                         input bit s, input logic [63:0] xmask);
    logic [63:0] v, keep;
    v    = rdata >> (8 * off);
    keep = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
    v    = v & keep;
    if (s && v[8*nb-1]) v = v | ~keep;
    return v & xmask;
  endfunction

  // Per-cycle compare against the model's expected bus and writeback events.
  always @(negedge clk) begin : cmp
    bit hw, hr;
    wb_t w;
    rq_t r;
    if (running && rst_n) begin
      hw = exp_wb.exists(cyc) != 0;
      hr = exp_req.exists(cyc) != 0;
      chk("wb_valid", 64'(dut_wbv), 64'(hw));
      chk("ram_req", 64'(dut_req), 64'(hr));
      chk("exec_ready", 64'(dut_rdy), 64'(!hr));
      if (hw) begin
        w = exp_wb[cyc];
        chk("wb_rd_en", 64'(dut_wbe), 64'(w.rd_en));
        chk("misalign", 64'(dut_mis), 64'(w.mis));
        chk("bus_err", 64'(dut_err), 64'(w.err));
        if (w.rd_en) chk("wb_rd", 64'(dut_wbrd), 64'(w.rd));
        if (w.chk_reg) chk("wb_rd_reg", dut_wbreg, w.reg_v);
        last_wb_reg = dut_wbreg;
      end else begin
        chk("wb_rd_en_idle", 64'(dut_wbe), 64'd0);
        chk("misalign_idle", 64'(dut_mis), 64'd0);
        chk("bus_err_idle", 64'(dut_err), 64'd0);
      end
      if (hr) begin
        r = exp_req[cyc];
        chk("ram_we", 64'(dut_we), 64'(r.we));
        chk("ram_addr", dut_addr, r.addr);
        chk("ram_mask", 64'(dut_mask), 64'(r.mask));
        chk("ram_wdata", dut_wdata, r.wdata);
        last_addr = dut_addr; last_mask = dut_mask; last_wdata = dut_wdata; last_we = dut_we;
      end else begin
        chk("ram_we_idle", 64'(dut_we), 64'd0);
        chk("ram_mask_idle", 64'(dut_mask), 64'd0);
      end
    end
  end

  // waits >= 0: ack after that many BUSY cycles; -1: never ack; -2: reset in first BUSY cycle.
  task automatic issue(input bit re, input logic [4:0] d, input logic [63:0] alu,
                       input bit l, input bit s, input logic [63:0] a, input logic [63:0] dat,
                       input logic [1:0] sz, input bit sg, input logic [63:0] rdat, input int waits);
    int xl, nb, off, n, e;
    bit mis;
    logic [63:0] xm;
    wb_t w;
    rq_t r;
    xl  = sel64 ? 64 : 32;
    xm  = sel64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
    nb  = 1 << sz;
    off = int'(a % 64'(xl / 8));
    mis = ((off % nb) != 0) || (sz == 2'd3 && xl == 32);
    exec_valid = 1'b1; rd_en = re; rd = d; rd_reg_in = alu & xm; ld = l; st = s;
    addr_in = a & xm; data_in = dat & xm; size = sz; sgn = sg; rdata_in = rdat & xm;
    e = cyc + 1;
    w = '{rd_en: 1'b0, rd: d, reg_v: 64'd0, mis: 1'b0, err: 1'b0, chk_reg: 1'b0};
    if (!(l || s)) begin
      w.rd_en = re; w.reg_v = alu & xm; w.chk_reg = 1'b1;
      exp_wb[e] = w;
      @(posedge clk); #1 exec_valid = 1'b0;
    end else if (mis) begin
      w.mis = 1'b1;
      exp_wb[e] = w;
      @(posedge clk); #1 exec_valid = 1'b0;
    end else begin
      r.we    = s && !l;
      r.addr  = a & xm & ~64'(xl / 8 - 1);
      r.mask  = 8'(((1 << nb) - 1) << off);
      r.wdata = ((dat & xm) << (8 * off)) & xm;
      n = (waits >= 0) ? waits + 1 : (waits == -1 ? TMO : 1);
      for (int c = 0; c < n; c++) exp_req[e + c] = r;
      if (waits == -1) begin
        w.err = 1'b1;
      end else if (l) begin
        w.rd_en = re; w.reg_v = m_load(rdat & xm, off, nb, sg, xm); w.chk_reg = 1'b1;
      end else begin
        w.chk_reg = 1'b1;
      end
      if (waits != -2) exp_wb[e + n] = w;
      @(posedge clk); #1 exec_valid = 1'b0;
      if (waits >= 0) begin
        repeat (waits) begin @(posedge clk); #1; end
        ack = 1'b1;
        @(posedge clk); #1 ack = 1'b0;
      end else if (waits == -1) begin
        repeat (TMO) begin @(posedge clk); #1; end
      end else begin
        @(negedge clk); #1 rst_n = 1'b0;
        #1;
        chk("reset_req_drop", 64'(dut_req), 64'd0);
        chk("reset_wb_valid", 64'(dut_wbv), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
      end
    end
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("rst_ram_req", 64'(dut_req), 64'd0);
    chk("rst_wb_valid", 64'(dut_wbv), 64'd0);
    chk("rst_ram_mask", 64'(dut_mask), 64'd0);
    chk("rst_wb_rd_reg", dut_wbreg, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; running = 1'b1;

    // 32-bit instance
    issue(1, 5'd5, 64'h1234_5678, 0, 0, 0, 0, 2'd0, 0, 0, 0);
    issue(1, 5'd0, 64'hDEAD_BEEF, 0, 0, 0, 0, 2'd0, 0, 0, 0);
    idle(2);
    issue(1, 5'd7, 0, 1, 0, 64'h1003, 0, 2'd0, 1, 64'h80FF_0000, 0);
    chk("lb_mask_lit", 64'(last_mask), 64'h8);
    chk("lb_addr_lit", last_addr, 64'h1000);
    chk("lb_rd_reg_lit", last_wb_reg, 64'hFFFF_FF80);
    issue(1, 5'd3, 0, 0, 1, 64'h2002, 64'h0000_ABCD, 2'd1, 0, 0, 1);
    chk("sh_mask_lit", 64'(last_mask), 64'hC);
    chk("sh_wdata_lit", last_wdata, 64'hABCD_0000);
    chk("sh_we_lit", 64'(last_we), 64'd1);
    issue(1, 5'd4, 0, 1, 0, 64'h3001, 0, 2'd2, 0, 0, 0);
    issue(1, 5'd4, 0, 1, 0, 64'h4000, 0, 2'd3, 0, 0, 0);
    issue(1, 5'd9, 0, 1, 0, 64'h1006, 0, 2'd1, 0, 64'h8001_0000, 2);
    chk("lhu_rd_reg_lit", last_wb_reg, 64'h0000_8001);
    issue(1, 5'd10, 0, 1, 1, 64'h5004, 64'h1111, 2'd2, 1, 64'hCAFE_F00D, 0);
    chk("ld_st_we_lit", 64'(last_we), 64'd0);
    issue(1, 5'd11, 0, 1, 0, 64'h6000, 0, 2'd2, 0, 64'h5555_5555, -1);
    issue(1, 5'd12, 0, 1, 0, 64'h6000, 0, 2'd2, 0, 64'h0123_4567, TMO - 1);
    chk("ack_at_limit_lit", last_wb_reg, 64'h0123_4567);
    issue(0, 5'd13, 0, 0, 1, 64'h7001, 64'h77, 2'd0, 0, 0, -1);
    ack = 1'b1; rdata_in = 64'hFFFF_FFFF;
    idle(1);
    ack = 1'b0;
    idle(1);
    issue(1, 5'd14, 0, 1, 0, 64'h1000, 0, 2'd2, 0, 64'h1, -2);
    idle(2);
    issue(1, 5'd15, 64'h0000_00A5, 0, 0, 0, 0, 2'd0, 0, 0, 0);

    // 64-bit instance
    sel64 = 1'b1;
    idle(1);
    issue(1, 5'd16, 0, 1, 0, 64'h8, 0, 2'd3, 0, 64'hFFFF_FFFF_0000_0000, 0);
    chk("ld_mask_lit", 64'(last_mask), 64'hFF);
    issue(1, 5'd17, 0, 1, 0, 64'hC, 0, 2'd2, 0, 64'hFFFF_FFFF_0000_0000, 0);
    chk("lwu_rd_reg_lit", last_wb_reg, 64'h0000_0000_FFFF_FFFF);
    issue(1, 5'd18, 0, 1, 0, 64'hC, 0, 2'd2, 1, 64'hFFFF_FFFF_0000_0000, 1);
    issue(1, 5'd19, 0, 0, 1, 64'hD, 64'h5A, 2'd0, 0, 0, 0);
    issue(1, 5'd20, 0, 1, 0, 64'h14, 0, 2'd2, 0, 0, 0);
    issue(1, 5'd21, 0, 1, 0, 64'h20, 0, 2'd3, 1, 0, -1);
    issue(1, 5'd22, 64'hFEDC_BA98_7654_3210, 0, 0, 0, 0, 2'd0, 0, 0, 0);
    idle(2);
    running = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
